vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 driver.
- Produces hsync/vsync, active-video flag, pixel coordinates, line/frame strobes and a frame counter from one system clock gated by a pixel-enable strobe.
- Configurable resolution, porches, sync polarity and output pipeline depth, so coordinates can be aligned with downstream character-ROM / glyph-lookup latency.
- Sits between the clock/reset logic and the digit-rendering pixel pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, asserted level of hsync (0 = active-low)
- V_POL, 0, asserted level of vsync
- X_W, 10, x output width; must satisfy 2^X_W >= H_ACTIVE
- Y_W, 9, y output width; must satisfy 2^Y_W >= V_ACTIVE
- PIPE, 1, output register stages; legal values are 1 to 8
- FC_W, 8, frame counter width

Ports:
- clk, input, 1, system clock; all logic on rising edge
- reset, input, 1, asynchronous active-low reset
- pix_en, input, 1, pixel strobe; counters and pipeline advance only on clk edges where pix_en=1
- hsync, output, 1, horizontal sync
- vsync, output, 1, vertical sync
- x, output, X_W, pixel column; 0 when valid=0
- y, output, Y_W, pixel row; 0 when valid=0
- valid, output, 1, active-video region
- line_start, output, 1, one-clk pulse when h=0 reaches the output
- frame_start, output, 1, one-clk pulse when (h,v)=(0,0) reaches the output
- frame_cnt, output, FC_W, completed-frame counter

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Internal counter widths are clog2 of each total.
- Counters:
  - h counts 0..H_TOTAL-1 and wraps to 0.
  - v increments when h wraps, and wraps to 0 after V_TOTAL-1.
  - Both counters update only on edges where pix_en=1.
- Combinational raw timing from (h,v):
  - act = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hs asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the full line (not pixel-aligned)
  - rx = act ? h[X_W-1:0] : 0; ry = act ? v[Y_W-1:0] : 0
- Pipeline:
  - Stage 1 captures raw {hs, vs, act, rx, ry, h==0, (h,v)==(0,0)} on a pix_en edge, using pre-edge counter values.
  - Stages 2..PIPE shift on pix_en edges only.
  - Final stage drives hsync, vsync, valid, x and y.
- Latency: the outputs reflect counter position P exactly PIPE pix_en edges after the counter held P. With pix_en held at 1, that is PIPE clk cycles.
- Polarity: hsync = hs ? H_POL : ~H_POL; vsync uses V_POL the same way.
- Strobes:
  - line_start = 1 for exactly one clk cycle after the pix_en edge that loads an h=0 entry into the final stage; 0 on every other cycle, including while pix_en=0.
  - frame_start behaves the same way for the (0,0) entry and coincides with a line_start pulse.
- frame_cnt increments by 1, modulo 2^FC_W, on the same edge that sets frame_start. It wraps from all-ones to 0 silently.
- Reset (asynchronous, reset=0):
  - h=v=0; all pipeline stages cleared to inactive values.
  - hsync=~H_POL, vsync=~V_POL, valid=0, x=0, y=0, line_start=0, frame_start=0, frame_cnt=0.
  - Reset mid-frame discards all state; no partial-frame strobe is emitted.
- Outputs after release: the first pix_en edge produces stage-1 content for (0,0), so the first frame_start occurs PIPE pix_en edges after release.
- pix_en=0 holds every output except the strobes, which drop to 0.

Test Plan:
- Reset values: hold reset=0 with pix_en toggling -> hsync=1, vsync=1, valid=0, x=y=0, frame_cnt=0, no strobes; asserting reset mid-line clears outputs immediately without waiting for a clk edge.
- Line timing (defaults, PIPE=1, pix_en=1): release reset ->
  - first frame_start/line_start on cycle 1, with x=0, y=0, valid=1
  - valid falls at cycle 641
  - hsync is low on cycles 657..752 and high again at cycle 753
  - the next line_start is at cycle 801 with y=1
- Frame timing (defaults): run 800*525 = 420000 cycles ->
  - vsync low for lines 490..491, i.e. 1600 cycles, starting at cycle 392001
  - second frame_start at cycle 420001 with frame_cnt=1
- Pixel-enable gating: pix_en high every 4th clk -> outputs change only after enabled edges; strobes last 1 clk; hsync low for 96 enabled pixels (384 clks).
- Small config: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, PIPE=3, H_POL=V_POL=1 ->
  - x sequence 0,1,2,3,0,0,0 per line, starting 3 cycles after release
  - hsync=1 only when h=5 reaches the output
  - vsync=1 only on line 3
  - frame period 35 cycles
- Frame counter wrap: FC_W=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters advanced by a pixel strobe,
// followed by a PIPE-deep registered pipeline so coordinates line up with downstream lookup latency.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int PIPE     = 1,
    parameter int FC_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pix_en,
    output logic            hsync,
    output logic            vsync,
    output logic [X_W-1:0]  x,
    output logic [Y_W-1:0]  y,
    output logic            valid,
    output logic            line_start,
    output logic            frame_start,
    output logic [FC_W-1:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int SW      = X_W + Y_W + 5;
    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
    localparam logic HP = (H_POL != 0);
    localparam logic VP = (V_POL != 0);

    logic [HC_W-1:0] h_q;
    logic [VC_W-1:0] v_q;
    logic [SW-1:0]   raw;
    logic [SW-1:0]   pipe_q [PIPE];
    logic [SW-1:0]   fin;
    logic            fin_fs_in;
    logic            en_q;
    logic [FC_W-1:0] fc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (pix_en) begin
            if (h_q == H_LAST) begin
                h_q <= '0;
                v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    // Stage entry layout: {hs, vs, act, rx, ry, line_first, frame_first}
    always_comb begin
        logic act, hs, vs;
        logic [X_W-1:0] rx;
        logic [Y_W-1:0] ry;
        act = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
        hs  = (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
        vs  = (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);
        rx  = act ? X_W'(h_q) : '0;
        ry  = act ? Y_W'(v_q) : '0;
        raw = {hs, vs, act, rx, ry, (h_q == '0), (h_q == '0) && (v_q == '0)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE; i++) pipe_q[i] <= '0;
        end else if (pix_en) begin
            pipe_q[0] <= raw;
            for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    if (PIPE == 1) begin : g_fin_raw
        assign fin_fs_in = raw[0];
    end else begin : g_fin_pipe
        assign fin_fs_in = pipe_q[PIPE-2][0];
    end

    // en_q marks that the last edge actually loaded the final stage, so strobes last one clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q <= 1'b0;
            fc_q <= '0;
        end else begin
            en_q <= pix_en;
            if (pix_en && fin_fs_in) fc_q <= fc_q + 1'b1;
        end
    end

    assign fin         = pipe_q[PIPE-1];
    assign hsync       = fin[SW-1] ? HP : ~HP;
    assign vsync       = fin[SW-2] ? VP : ~VP;
    assign valid       = fin[SW-3];
    assign x           = fin[SW-4 -: X_W];
    assign y           = fin[Y_W+1 -: Y_W];
    assign line_start  = en_q & fin[1];
    assign frame_start = en_q & fin[0];
    assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small PIPE=3 config and the default 640x480 config side by side,
// checked by vector tables, hand sequences and an arithmetic position model under random pix_en.
module tb_vga_timing_gen;
    logic clk = 1'b0, reset = 1'b0, pix_en = 1'b0;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_valid, a_ls, a_fs;
    logic [1:0] a_x;
    logic [0:0] a_y;
    logic [1:0] a_fc;
    logic       b_hs, b_vs, b_valid, b_ls, b_fs;
    logic [9:0] b_x;
    logic [8:0] b_y;
    logic [7:0] b_fc;

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                     .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1), .V_POL(1), .X_W(2), .Y_W(1), .PIPE(3), .FC_W(2)) u_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(a_hs), .vsync(a_vs),
        .x(a_x), .y(a_y), .valid(a_valid), .line_start(a_ls), .frame_start(a_fs),
        .frame_cnt(a_fc));

    vga_timing_gen u_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(b_hs), .vsync(b_vs),
        .x(b_x), .y(b_y), .valid(b_valid), .line_start(b_ls), .frame_start(b_fs),
        .frame_cnt(b_fc));

    int n_tests = 0, n_fail = 0;

    task automatic cmp(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model state: enabled edges since reset release, and whether the latest edge was enabled.
    int m_n;
    bit m_en;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_n  <= 0;
            m_en <= 1'b0;
        end else begin
            m_en <= pix_en;
            if (pix_en) m_n <= m_n + 1;
        end
    end

    typedef struct { int hs, vs, valid, x, y, ls, fs, fc; } exp_t;

    function automatic exp_t model(int n, bit en_last, int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp, int pipe,
                                   int hpol, int vpol, int fcw);
        exp_t e;
        int ht, vt, p, h, v;
        bit act;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        e = '{hs: 1 - hpol, vs: 1 - vpol, valid: 0, x: 0, y: 0, ls: 0, fs: 0, fc: 0};
        if (n >= pipe) begin
            p   = (n - pipe) % (ht * vt);
            h   = p % ht;
            v   = p / ht;
            act = (h < ha) && (v < va);
            e.valid = act;
            e.x  = act ? h : 0;
            e.y  = act ? v : 0;
            e.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : 1 - hpol;
            e.vs = (v >= va + vfp && v < va + vfp + vsw) ? vpol : 1 - vpol;
            e.ls = en_last && (h == 0);
            e.fs = en_last && (p == 0);
            e.fc = ((n - pipe) / (ht * vt) + 1) % (1 << fcw);
        end
        return e;
    endfunction

    task automatic check_model();
        exp_t ea, eb;
        ea = model(m_n, m_en, 4, 1, 1, 1, 2, 1, 1, 1, 3, 1, 1, 2);
        eb = model(m_n, m_en, 640, 16, 96, 48, 480, 10, 2, 33, 1, 0, 0, 8);
        cmp("a_hsync", a_hs, ea.hs);   cmp("a_vsync", a_vs, ea.vs);
        cmp("a_valid", a_valid, ea.valid);
        cmp("a_x", a_x, ea.x);         cmp("a_y", a_y, ea.y);
        cmp("a_line_start", a_ls, ea.ls); cmp("a_frame_start", a_fs, ea.fs);
        cmp("a_frame_cnt", a_fc, ea.fc);
        cmp("b_hsync", b_hs, eb.hs);   cmp("b_vsync", b_vs, eb.vs);
        cmp("b_valid", b_valid, eb.valid);
        cmp("b_x", b_x, eb.x);         cmp("b_y", b_y, eb.y);
        cmp("b_line_start", b_ls, eb.ls); cmp("b_frame_start", b_fs, eb.fs);
        cmp("b_frame_cnt", b_fc, eb.fc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct { int sel, c, x, y, valid, hs, vs, ls, fs, fc; } vec_t;
    vec_t tbl[$];

    initial begin
        int cyc, hs_low, ls_cnt, ls_back2back;
        bit prev_ls;

        // sel 0 = small config (PIPE=3, active-high syncs), sel 1 = default 640x480
        //              sel  cyc   x  y  vld hs vs ls fs fc
        tbl.push_back('{0,   1,    0, 0, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{1,   1,    0, 0, 1,  1, 1, 1, 1, 1});
        tbl.push_back('{1,   2,    1, 0, 1,  1, 1, 0, 0, 1});
        tbl.push_back('{0,   3,    0, 0, 1,  0, 0, 1, 1, 1});
        tbl.push_back('{0,   4,    1, 0, 1,  0, 0, 0, 0, 1});
        tbl.push_back('{0,   6,    3, 0, 1,  0, 0, 0, 0, 1});
        tbl.push_back('{0,   7,    0, 0, 0,  0, 0, 0, 0, 1});
        tbl.push_back('{0,   8,    0, 0, 0,  1, 0, 0, 0, 1});
        tbl.push_back('{0,   9,    0, 0, 0,  0, 0, 0, 0, 1});
        tbl.push_back('{0,  10,    0, 1, 1,  0, 0, 1, 0, 1});
        tbl.push_back('{0,  24,    0, 0, 0,  0, 1, 1, 0, 1});
        tbl.push_back('{0,  38,    0, 0, 1,  0, 0, 1, 1, 2});
        tbl.push_back('{0,  73,    0, 0, 1,  0, 0, 1, 1, 3});
        tbl.push_back('{0, 108,    0, 0, 1,  0, 0, 1, 1, 0});
        tbl.push_back('{0, 143,    0, 0, 1,  0, 0, 1, 1, 1});
        tbl.push_back('{1, 640,  639, 0, 1,  1, 1, 0, 0, 1});
        tbl.push_back('{1, 641,    0, 0, 0,  1, 1, 0, 0, 1});
        tbl.push_back('{1, 656,    0, 0, 0,  1, 1, 0, 0, 1});
        tbl.push_back('{1, 657,    0, 0, 0,  0, 1, 0, 0, 1});
        tbl.push_back('{1, 752,    0, 0, 0,  0, 1, 0, 0, 1});
        tbl.push_back('{1, 753,    0, 0, 0,  1, 1, 0, 0, 1});
        tbl.push_back('{1, 801,    0, 1, 1,  1, 1, 1, 0, 1});

        // Reset held while pix_en toggles: reset values, no strobes.
        for (int i = 0; i < 6; i++) begin
            pix_en = i[0];
            tick();
            check_model();
        end

        reset  = 1'b1;
        pix_en = 1'b1;
        cyc    = 0;
        foreach (tbl[i]) begin
            while (cyc < tbl[i].c) begin
                tick();
                cyc++;
            end
            if (tbl[i].sel == 0) begin
                cmp($sformatf("row%0d_x", i), a_x, tbl[i].x);
                cmp($sformatf("row%0d_y", i), a_y, tbl[i].y);
                cmp($sformatf("row%0d_valid", i), a_valid, tbl[i].valid);
                cmp($sformatf("row%0d_hsync", i), a_hs, tbl[i].hs);
                cmp($sformatf("row%0d_vsync", i), a_vs, tbl[i].vs);
                cmp($sformatf("row%0d_line_start", i), a_ls, tbl[i].ls);
                cmp($sformatf("row%0d_frame_start", i), a_fs, tbl[i].fs);
                cmp($sformatf("row%0d_frame_cnt", i), a_fc, tbl[i].fc);
            end else begin
                cmp($sformatf("row%0d_x", i), b_x, tbl[i].x);
                cmp($sformatf("row%0d_y", i), b_y, tbl[i].y);
                cmp($sformatf("row%0d_valid", i), b_valid, tbl[i].valid);
                cmp($sformatf("row%0d_hsync", i), b_hs, tbl[i].hs);
                cmp($sformatf("row%0d_vsync", i), b_vs, tbl[i].vs);
                cmp($sformatf("row%0d_line_start", i), b_ls, tbl[i].ls);
                cmp($sformatf("row%0d_frame_start", i), b_fs, tbl[i].fs);
                cmp($sformatf("row%0d_frame_cnt", i), b_fc, tbl[i].fc);
            end
        end

        // Mid-line asynchronous reset: outputs clear without any clk edge.
        while (cyc < 820) begin
            tick();
            cyc++;
        end
        cmp("pre_reset_b_valid", b_valid, 1);
        cmp("pre_reset_b_x", b_x, 19);
        #3 reset = 1'b0;
        #1;
        cmp("async_b_valid", b_valid, 0);
        cmp("async_b_x", b_x, 0);
        cmp("async_b_y", b_y, 0);
        cmp("async_b_hsync", b_hs, 1);
        cmp("async_b_frame_cnt", b_fc, 0);
        cmp("async_a_valid", a_valid, 0);
        cmp("async_a_hsync", a_hs, 0);
        for (int i = 0; i < 8; i++) begin
            pix_en = i[0];
            tick();
            check_model();
        end

        // pix_en every 4th clk: hsync low for 96 enabled pixels, strobes one clk wide.
        reset  = 1'b1;
        hs_low = 0;
        ls_cnt = 0;
        ls_back2back = 0;
        prev_ls = 1'b0;
        for (int i = 0; i < 3400; i++) begin
            pix_en = (i % 4 == 0);
            tick();
            check_model();
            if (!b_hs) hs_low++;
            if (b_ls) ls_cnt++;
            if (b_ls && prev_ls) ls_back2back++;
            prev_ls = b_ls;
        end
        cmp("gated_hsync_low_clks", hs_low, 384);
        cmp("gated_line_start_clks", ls_cnt, 2);
        cmp("gated_strobe_back2back", ls_back2back, 0);

        // Random pix_en against the position model, with one mid-run reset.
        pix_en = 1'b0;
        reset  = 1'b0;
        tick();
        check_model();
        reset = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            pix_en = ($urandom_range(0, 3) != 0);
            if (i == 15000) begin
                reset = 1'b0;
                #1 check_model();
                reset = 1'b1;
            end
            tick();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
